// File: rtl/decode_stage.sv
// decode_stage: multi-lane RV32I decoder into one-hot unit/op fields, registered behind a one-entry skid buffer.
// Optional DECODE_PERF_CNT_EN adds delivered-instruction and skid-stall counters.
module decode_stage #(
  parameter int LANES = 2,
  parameter int XLEN = 32,
  localparam int NB_UNIT = 6,
  localparam int NB_OPERATION = 6,
  localparam int NB_REGS = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  logic [LANES-1:0]             if_valid_i,
  input  logic [LANES*32-1:0]          if_instr_i,
  input  logic [LANES*XLEN-1:0]        if_pc_i,
  output logic                         if_ready_o,
  output logic [LANES-1:0]             dec_valid_o,
  input  logic                         dec_ready_i,
  output logic [LANES*NB_UNIT-1:0]     dec_unit_o,
  output logic [LANES*NB_OPERATION-1:0] dec_op_o,
  output logic [LANES-1:0]             dec_mod_o,
  output logic [LANES*2-1:0]           dec_size_o,
  output logic [LANES*NB_REGS-1:0]     dec_rd_o,
  output logic [LANES*NB_REGS-1:0]     dec_rs1_o,
  output logic [LANES*NB_REGS-1:0]     dec_rs2_o,
  output logic [LANES-1:0]             dec_use_imm_o,
  output logic [LANES-1:0]             dec_use_pc_o,
  output logic [LANES*XLEN-1:0]        dec_imm_o,
  output logic [LANES*XLEN-1:0]        dec_pc_o,
  output logic [LANES-1:0]             dec_illegal_o,
  output logic [1:0]                   dbg_state
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_dec_cnt_o,
  output logic [31:0]                  perf_stall_cnt_o
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_SKID  = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [5:0] U_ALU = 6'b000001;
  localparam logic [5:0] U_SFT = 6'b000010;
  localparam logic [5:0] U_BU  = 6'b000100;
  localparam logic [5:0] U_LSU = 6'b001000;

  // Operation bits are one-hot within the selected unit.
  localparam logic [5:0] ALU_ADD = 6'b000001, ALU_AND = 6'b000010, ALU_OR  = 6'b000100;
  localparam logic [5:0] ALU_XOR = 6'b001000, ALU_SLT = 6'b010000;
  localparam logic [5:0] SFT_SLL = 6'b000001, SFT_SRL = 6'b000010, SFT_SRA = 6'b000100;
  localparam logic [5:0] BU_BEQ  = 6'b000001, BU_BNE  = 6'b000010, BU_BLT  = 6'b000100;
  localparam logic [5:0] BU_BGE  = 6'b001000, BU_JAL  = 6'b010000, BU_JALR = 6'b100000;
  localparam logic [5:0] LSU_LD  = 6'b000001, LSU_ST  = 6'b000010;

  typedef struct packed {
    logic [NB_UNIT-1:0]      unit;
    logic [NB_OPERATION-1:0] op;
    logic                    modifier;
    logic [1:0]              size;
    logic [NB_REGS-1:0]      rd;
    logic [NB_REGS-1:0]      rs1;
    logic [NB_REGS-1:0]      rs2;
    logic                    use_imm;
    logic                    use_pc;
    logic [XLEN-1:0]         imm;
    logic [XLEN-1:0]         pc;
    logic                    illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    dec_t d;
    logic ill;
    logic [31:0] imm;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    d   = '0;
    ill = 1'b0;
    imm = {{20{ins[31]}}, ins[31:20]};
    d.pc = pc;
    case (opc)
      OPC_OP, OPC_OP_IMM: begin
        d.unit = U_ALU;
        d.rd   = ins[11:7];
        d.rs1  = ins[19:15];
        if (opc == OPC_OP) d.rs2 = ins[24:20];
        else d.use_imm = 1'b1;
        case (f3)
          3'b000: begin d.op = ALU_ADD; d.modifier = (opc == OPC_OP) && (f7 == F7_ALT); end
          3'b001: begin d.unit = U_SFT; d.op = SFT_SLL; end
          3'b010: d.op = ALU_SLT;
          3'b011: begin d.op = ALU_SLT; d.modifier = 1'b1; end
          3'b100: d.op = ALU_XOR;
          3'b101: begin d.unit = U_SFT; d.op = (f7 == F7_ALT) ? SFT_SRA : SFT_SRL; end
          3'b110: d.op = ALU_OR;
          default: d.op = ALU_AND;
        endcase
        // Shift immediates carry only the shamt; funct7 is an encoding field, not data.
        if (f3 == 3'b001 || f3 == 3'b101) imm = {27'b0, ins[24:20]};
        if (f3 == 3'b001) ill = (f7 != 7'b0);
        else if (f3 == 3'b101 || (f3 == 3'b000 && opc == OPC_OP)) ill = (f7 != 7'b0) && (f7 != F7_ALT);
        else if (opc == OPC_OP) ill = (f7 != 7'b0);
      end
      OPC_BRANCH: begin
        d.unit = U_BU;
        d.rs1  = ins[19:15];
        d.rs2  = ins[24:20];
        imm    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        d.modifier = f3[1];
        case (f3)
          3'b000: d.op = BU_BEQ;
          3'b001: d.op = BU_BNE;
          3'b100, 3'b110: d.op = BU_BLT;
          3'b101, 3'b111: d.op = BU_BGE;
          default: ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        d.unit = U_BU; d.op = BU_JAL; d.rd = ins[11:7]; d.use_imm = 1'b1;
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        d.unit = U_BU; d.op = BU_JALR; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.use_imm = 1'b1;
        ill = (f3 != 3'b000);
      end
      OPC_LOAD: begin
        d.unit = U_LSU; d.op = LSU_LD; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.use_imm = 1'b1;
        d.size = f3[1:0];
        d.modifier = f3[2];
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        d.unit = U_LSU; d.op = LSU_ST; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.use_imm = 1'b1;
        d.size = f3[1:0];
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ill = f3[2] || (f3[1:0] == 2'b11);
      end
      OPC_LUI, OPC_AUIPC: begin
        d.unit = U_ALU; d.op = ALU_ADD; d.rd = ins[11:7]; d.use_imm = 1'b1;
        d.use_pc = (opc == OPC_AUIPC);
        imm = {ins[31:12], 12'b0};
      end
      OPC_FENCE: begin
        d.unit = U_ALU; d.op = ALU_ADD; d.use_imm = 1'b1;
        imm = '0;
      end
      default: ill = 1'b1;
    endcase
    d.imm = XLEN'($signed(imm));
    // Illegal lanes carry no work but keep their PC so commit can raise the trap.
    if (ill) begin
      d = '0;
      d.pc = pc;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  dec_t [LANES-1:0] dec_next;
  dec_t [LANES-1:0] out_d;
  dec_t [LANES-1:0] skid_d;
  logic [LANES-1:0] out_vld;
  logic [LANES-1:0] skid_vld;
  logic [1:0]       state;
  logic             ready_q;
  logic             in_fire;
  logic             out_fire;

  always_comb begin
    dec_next = '0;
    for (int l = 0; l < LANES; l++)
      dec_next[l] = decode(if_instr_i[l*32 +: 32], if_pc_i[l*XLEN +: XLEN]);
  end

  // Handshake: a bundle enters when any if_valid_i bit is set while if_ready_o is high, and
  // leaves when any dec_valid_o bit is set while dec_ready_i is high; whole bundles only.
  assign in_fire  = (|if_valid_i) && ready_q;
  assign out_fire = (|out_vld) && dec_ready_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_EMPTY;
      ready_q  <= 1'b1;
      out_vld  <= '0;
      out_d    <= '0;
      skid_vld <= '0;
      skid_d   <= '0;
    end else if (flush_i) begin
      state    <= S_EMPTY;
      ready_q  <= 1'b1;
      out_vld  <= '0;
      skid_vld <= '0;
    end else begin
      case (state)
        S_EMPTY: if (in_fire) begin
          out_vld <= if_valid_i;
          out_d   <= dec_next;
          state   <= S_FULL;
        end
        S_FULL: begin
          if (in_fire && out_fire) begin
            out_vld <= if_valid_i;
            out_d   <= dec_next;
          end else if (out_fire) begin
            out_vld <= '0;
            state   <= S_EMPTY;
          end else if (in_fire) begin
            skid_vld <= if_valid_i;
            skid_d   <= dec_next;
            state    <= S_SKID;
            ready_q  <= 1'b0;
          end
        end
        S_SKID: if (out_fire) begin
          out_vld  <= skid_vld;
          out_d    <= skid_d;
          skid_vld <= '0;
          state    <= S_FULL;
          ready_q  <= 1'b1;
        end
        default: begin
          state   <= S_EMPTY;
          ready_q <= 1'b1;
          out_vld <= '0;
        end
      endcase
    end
  end

  assign if_ready_o  = ready_q;
  assign dec_valid_o = out_vld;
  assign dbg_state   = state;

  for (genvar l = 0; l < LANES; l++) begin : g_out
    assign dec_unit_o[l*NB_UNIT +: NB_UNIT]           = out_d[l].unit;
    assign dec_op_o[l*NB_OPERATION +: NB_OPERATION]   = out_d[l].op;
    assign dec_mod_o[l]                               = out_d[l].modifier;
    assign dec_size_o[l*2 +: 2]                       = out_d[l].size;
    assign dec_rd_o[l*NB_REGS +: NB_REGS]             = out_d[l].rd;
    assign dec_rs1_o[l*NB_REGS +: NB_REGS]            = out_d[l].rs1;
    assign dec_rs2_o[l*NB_REGS +: NB_REGS]            = out_d[l].rs2;
    assign dec_use_imm_o[l]                           = out_d[l].use_imm;
    assign dec_use_pc_o[l]                            = out_d[l].use_pc;
    assign dec_imm_o[l*XLEN +: XLEN]                  = out_d[l].imm;
    assign dec_pc_o[l*XLEN +: XLEN]                   = out_d[l].pc;
    assign dec_illegal_o[l]                           = out_d[l].illegal;
  end

`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_dec_cnt_o   <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (out_fire && !flush_i) perf_dec_cnt_o <= perf_dec_cnt_o + 32'($countones(out_vld));
      if (state == S_SKID) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid stall, flush and illegal encodings,
// with an in-order delivery scoreboard keyed on lane-0 PC.
module tb_decode_stage;
  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam logic [1:0] S_EMPTY = 2'd0, S_FULL = 2'd1, S_SKID = 2'd2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  flush_i;
  logic [LANES-1:0]      if_valid_i;
  logic [LANES*32-1:0]   if_instr_i;
  logic [LANES*XLEN-1:0] if_pc_i;
  logic                  if_ready_o;
  logic [LANES-1:0]      dec_valid_o;
  logic                  dec_ready_i;
  logic [LANES*6-1:0]    dec_unit_o;
  logic [LANES*6-1:0]    dec_op_o;
  logic [LANES-1:0]      dec_mod_o;
  logic [LANES*2-1:0]    dec_size_o;
  logic [LANES*5-1:0]    dec_rd_o;
  logic [LANES*5-1:0]    dec_rs1_o;
  logic [LANES*5-1:0]    dec_rs2_o;
  logic [LANES-1:0]      dec_use_imm_o;
  logic [LANES-1:0]      dec_use_pc_o;
  logic [LANES*XLEN-1:0] dec_imm_o;
  logic [LANES*XLEN-1:0] dec_pc_o;
  logic [LANES-1:0]      dec_illegal_o;
  logic [1:0]            dbg_state;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]           perf_dec_cnt_o;
  logic [31:0]           perf_stall_cnt_o;
`endif

  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  decode_stage #(.LANES(LANES), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i), .if_ready_o(if_ready_o),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_unit_o(dec_unit_o), .dec_op_o(dec_op_o), .dec_mod_o(dec_mod_o), .dec_size_o(dec_size_o),
    .dec_rd_o(dec_rd_o), .dec_rs1_o(dec_rs1_o), .dec_rs2_o(dec_rs2_o),
    .dec_use_imm_o(dec_use_imm_o), .dec_use_pc_o(dec_use_pc_o),
    .dec_imm_o(dec_imm_o), .dec_pc_o(dec_pc_o), .dec_illegal_o(dec_illegal_o),
    .dbg_state(dbg_state)
`ifdef DECODE_PERF_CNT_EN
    , .perf_dec_cnt_o(perf_dec_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc);
    if_valid_i = v;
    if_instr_i = {i1, i0};
    if_pc_i    = {pc + 32'd4, pc};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: the handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if ((|dec_valid_o) && dec_ready_i) begin
          if (exp_q.size() == 0) check("sb_unexpected", {62'b0, dec_valid_o}, 64'h0);
          else check("sb_order", dec_pc_o[XLEN-1:0], exp_q.pop_front());
        end
        if ((|if_valid_i) && if_ready_o) exp_q.push_back(if_pc_i[XLEN-1:0]);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    flush_i = 1'b0;
    dec_ready_i = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", if_ready_o, 1);
    check("rst_valid", dec_valid_o, 0);
    check("rst_state", dbg_state, S_EMPTY);
    check("rst_unit", dec_unit_o, 0);
    check("rst_imm", dec_imm_o, 0);
    reset_n = 1'b1;
    tick();

    // add x3,x1,x2 on lane 0
    drive(2'b01, 32'h002081B3, 32'h0, 32'h100);
    tick();
    check("add_valid", dec_valid_o, 2'b01);
    check("add_unit", dec_unit_o[5:0], 6'b000001);
    check("add_op", dec_op_o[5:0], 6'b000001);
    check("add_mod", dec_mod_o[0], 0);
    check("add_rd", dec_rd_o[4:0], 3);
    check("add_rs1", dec_rs1_o[4:0], 1);
    check("add_rs2", dec_rs2_o[4:0], 2);

    // sub lane 0, lw x5,8(x2) lane 1
    drive(2'b11, 32'h402081B3, 32'h00812283, 32'h200);
    tick();
    check("sub_valid", dec_valid_o, 2'b11);
    check("sub_mod", dec_mod_o[0], 1);
    check("sub_unit", dec_unit_o[5:0], 6'b000001);
    check("lw_unit", dec_unit_o[11:6], 6'b001000);
    check("lw_op", dec_op_o[11:6], 6'b000001);
    check("lw_imm", dec_imm_o[63:32], 8);
    check("lw_size", dec_size_o[3:2], 2);
    check("lw_rd", dec_rd_o[9:5], 5);
    check("lw_useimm", dec_use_imm_o[1], 1);
    drive(2'b00, 32'h0, 32'h0, 32'h0);
    tick();
    check("drain_valid", dec_valid_o, 0);

    // Downstream stalled for three edges while two bundles arrive
    dec_ready_i = 1'b0;
    drive(2'b01, 32'h00500093, 32'h0, 32'h300);
    tick();
    check("stall_a_ready", if_ready_o, 1);
    drive(2'b01, 32'h0FF0F113, 32'h0, 32'h304);
    tick();
    check("skid_ready", if_ready_o, 0);
    check("skid_state", dbg_state, S_SKID);
    check("skid_hold_pc", dec_pc_o[31:0], 32'h300);
    check("skid_hold_imm", dec_imm_o[31:0], 5);
    drive(2'b00, 32'h0, 32'h0, 32'h0);
    tick();
    check("skid_hold2_pc", dec_pc_o[31:0], 32'h300);
    check("skid_hold2_ready", if_ready_o, 0);
    dec_ready_i = 1'b1;
    tick();
    check("unskid_pc", dec_pc_o[31:0], 32'h304);
    check("unskid_op", dec_op_o[5:0], 6'b000010);
    check("unskid_imm", dec_imm_o[31:0], 32'hFF);
    check("unskid_ready", if_ready_o, 1);
    check("unskid_state", dbg_state, S_FULL);
    tick();
    check("unskid_drain", dec_valid_o, 0);
    check("unskid_empty", dbg_state, S_EMPTY);

    // Flush while a bundle is parked in the skid register
    dec_ready_i = 1'b0;
    drive(2'b01, 32'h00500093, 32'h0, 32'h400);
    tick();
    drive(2'b01, 32'h00500093, 32'h0, 32'h404);
    tick();
    check("flush_pre_state", dbg_state, S_SKID);
    flush_i = 1'b1;
    drive(2'b01, 32'h00500093, 32'h0, 32'h500);
    tick();
    flush_i = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 32'h0);
    check("flush_valid", dec_valid_o, 0);
    check("flush_ready", if_ready_o, 1);
    check("flush_state", dbg_state, S_EMPTY);
    dec_ready_i = 1'b1;
    tick();
    tick();
    check("flush_nothing_out", dec_valid_o, 0);

    // Flush in FULL drops the bundle presented in the flush cycle
    dec_ready_i = 1'b0;
    drive(2'b01, 32'h00500093, 32'h0, 32'h600);
    tick();
    check("ffull_state", dbg_state, S_FULL);
    flush_i = 1'b1;
    drive(2'b01, 32'h00500093, 32'h0, 32'h604);
    tick();
    flush_i = 1'b0;
    dec_ready_i = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 32'h0);
    check("ffull_valid", dec_valid_o, 0);
    check("ffull_state2", dbg_state, S_EMPTY);
    tick();
    check("ffull_dropped", dec_valid_o, 0);

    // ecall and an unknown opcode are illegal but stay valid
    drive(2'b11, 32'h00000073, 32'h0000007B, 32'h700);
    tick();
    check("ill_valid", dec_valid_o, 2'b11);
    check("ill_flag", dec_illegal_o, 2'b11);
    check("ill_unit", dec_unit_o, 0);
    check("ill_op", dec_op_o, 0);

    // Only lane 1 valid
    drive(2'b10, 32'h002081B3, 32'h002081B3, 32'h800);
    tick();
    check("l1only_valid", dec_valid_o, 2'b10);
    check("l1only_unit", dec_unit_o[11:6], 6'b000001);
    check("l1only_ill", dec_illegal_o, 2'b00);

    // bltu x1,x2,+16 and sb x5,-4(x2)
    drive(2'b11, 32'h0020E863, 32'hFE510E23, 32'h900);
    tick();
    check("bltu_unit", dec_unit_o[5:0], 6'b000100);
    check("bltu_op", dec_op_o[5:0], 6'b000100);
    check("bltu_mod", dec_mod_o[0], 1);
    check("bltu_imm", dec_imm_o[31:0], 16);
    check("bltu_rd", dec_rd_o[4:0], 0);
    check("sb_unit", dec_unit_o[11:6], 6'b001000);
    check("sb_op", dec_op_o[11:6], 6'b000010);
    check("sb_size", dec_size_o[3:2], 0);
    check("sb_imm", dec_imm_o[63:32], 32'hFFFFFFFC);
    check("sb_rs2", dec_rs2_o[9:5], 5);

    // auipc x7,0x12345 and sra x1,x2,x3
    drive(2'b11, 32'h12345397, 32'h403150B3, 32'hA00);
    tick();
    check("auipc_usepc", dec_use_pc_o, 2'b01);
    check("auipc_imm", dec_imm_o[31:0], 32'h12345000);
    check("auipc_rd", dec_rd_o[4:0], 7);
    check("sra_unit", dec_unit_o[11:6], 6'b000010);
    check("sra_op", dec_op_o[11:6], 6'b000100);

    // slli with funct7=0x20 is illegal; jal x1,+8
    drive(2'b11, 32'h40009093, 32'h008000EF, 32'hB00);
    tick();
    check("slli_bad_ill", dec_illegal_o, 2'b01);
    check("slli_bad_unit", dec_unit_o[5:0], 0);
    check("jal_unit", dec_unit_o[11:6], 6'b000100);
    check("jal_op", dec_op_o[11:6], 6'b010000);
    check("jal_rd", dec_rd_o[9:5], 1);
    check("jal_imm", dec_imm_o[63:32], 8);

    drive(2'b00, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
